sprite_lane_pool: RTL

SPRITE_LANE_POOL -- requirements
Module: sprite_lane_pool

---
 rtl/sprite_lane_pool_if.sv | 23 ++
 rtl/sprite_lane_pool.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sprite_lane_pool_if.sv
// Pixel probe, per-lane request strobes and per-lane event pulses of sprite_lane_pool.
interface sprite_lane_pool_if #(
   parameter int NUM_LANES = 4
);
   logic [9:0]           DrawX;
   logic [9:0]           DrawY;
   logic [NUM_LANES-1:0] spawn_req;
   logic [NUM_LANES-1:0] hit_req;
   logic [NUM_LANES-1:0] is_sprite;
   logic [NUM_LANES-1:0] hit_pulse;
   logic [NUM_LANES-1:0] miss_pulse;
   logic [NUM_LANES-1:0] drop_pulse;

   modport master (
      output DrawX, DrawY, spawn_req, hit_req,
      input  is_sprite, hit_pulse, miss_pulse, drop_pulse
   );

   modport slave (
      input  DrawX, DrawY, spawn_req, hit_req,
      output is_sprite, hit_pulse, miss_pulse, drop_pulse
   );
endinterface

// File: rtl/sprite_lane_pool.sv
// Pool of left-scrolling sprites in independent lanes: spawn on frame tick, move,
// expire at the left edge, and remove on player hit.
module sprite_lane_pool #(
   parameter int NUM_LANES = 4,
   parameter int SLOTS     = 4,
   parameter int X_START   = 639,
   parameter int X_STEP    = 3,
   parameter int SIZE      = 40,
   parameter int Y_BASE    = 160,
   parameter int Y_PITCH   = 0,
   parameter int HIT_X_MAX = 120
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                frame_clk,
   sprite_lane_pool_if.slave   bus
);
   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   logic sync1, sync2, sync3, tick;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= frame_clk;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign tick = sync2 & ~sync3;

   logic [NUM_LANES-1:0] sprite_v, hit_v, miss_v, drop_v;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      localparam logic [10:0] YTOP = 11'(Y_BASE + l * Y_PITCH);

      logic [SLOTS-1:0] valid, valid_nx;
      logic [9:0]       x [SLOTS];
      logic [9:0]       x_nx [SLOTS];
      logic             pending, pending_nx, pend_eff;
      logic             hit_found, hit_take, free_found, tick_miss;
      logic [IDX_W-1:0] hit_idx, free_idx;
      logic [9:0]       hit_x;
      logic             hit_q, miss_q, drop_q, on_sprite;

      // Hit target is the hittable slot with the smallest x; strict '<' keeps the lowest index on ties.
      always_comb begin
         hit_found  = 1'b0;
         hit_idx    = '0;
         hit_x      = '1;
         free_found = 1'b0;
         free_idx   = '0;
         for (int unsigned i = 0; i < SLOTS; i++) begin
            if (valid[i] && x[i] <= 10'(HIT_X_MAX) && (!hit_found || x[i] < hit_x)) begin
               hit_found = 1'b1;
               hit_idx   = IDX_W'(i);
               hit_x     = x[i];
            end
            if (!valid[i] && !free_found) begin
               free_found = 1'b1;
               free_idx   = IDX_W'(i);
            end
         end
      end

      assign hit_take = bus.hit_req[l] & hit_found;
      assign pend_eff = pending | bus.spawn_req[l];

      // Free slot is chosen from pre-tick validity, so slots vacated this cycle stay empty until next tick.
      always_comb begin
         valid_nx   = valid;
         x_nx       = x;
         tick_miss  = 1'b0;
         pending_nx = tick ? 1'b0 : pend_eff;
         for (int unsigned i = 0; i < SLOTS; i++) begin
            if (hit_take && hit_idx == IDX_W'(i)) begin
               valid_nx[i] = 1'b0;
            end else if (tick && valid[i]) begin
               if ({1'b0, x[i]} < 11'(X_STEP)) begin
                  valid_nx[i] = 1'b0;
                  tick_miss   = 1'b1;
               end else begin
                  x_nx[i] = x[i] - 10'(X_STEP);
               end
            end
         end
         if (tick && pend_eff && free_found) begin
            valid_nx[free_idx] = 1'b1;
            x_nx[free_idx]     = 10'(X_START);
         end
      end

      always_ff @(posedge Clk or negedge Reset) begin
         if (!Reset) begin
            valid   <= '0;
            pending <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            drop_q  <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) x[i] <= '0;
         end else begin
            valid   <= valid_nx;
            x       <= x_nx;
            pending <= pending_nx;
            hit_q   <= hit_take;
            miss_q  <= tick_miss | (bus.hit_req[l] & ~hit_found);
            drop_q  <= tick & pend_eff & ~free_found;
         end
      end

      // 11-bit bounds so a sprite near the right edge clips instead of wrapping.
      always_comb begin
         on_sprite = 1'b0;
         for (int unsigned i = 0; i < SLOTS; i++) begin
            if (valid[i] &&
                {1'b0, bus.DrawX} >= {1'b0, x[i]} &&
                {1'b0, bus.DrawX} <  {1'b0, x[i]} + 11'(SIZE) &&
                {1'b0, bus.DrawY} >= YTOP &&
                {1'b0, bus.DrawY} <  YTOP + 11'(SIZE))
               on_sprite = 1'b1;
         end
      end

      assign sprite_v[l] = on_sprite;
      assign hit_v[l]    = hit_q;
      assign miss_v[l]   = miss_q;
      assign drop_v[l]   = drop_q;
   end

   assign bus.is_sprite  = sprite_v;
   assign bus.hit_pulse  = hit_v;
   assign bus.miss_pulse = miss_v;
   assign bus.drop_pulse = drop_v;
endmodule
